// File: rtl/cmp_arb_pkg.sv
// Shared types and helpers for the comparator-sharing arbiter.
// The round-robin search covers up to MAX_REQ requesters.
package cmp_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CMP_W    = 4;
    localparam int MAX_REQ  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Returns {found, index}. The search runs upward from ptr and wraps at nreq.
    // Offsets are visited from far to near so that the nearest set bit wins.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [3:0] res;
        int         off;
        int         idx;
        res = 4'b0000;
        for (int k = 0; k < MAX_REQ; k++) begin
            off = MAX_REQ - 1 - k;
            if (off < nreq) begin
                idx = (int'(ptr) + off) % nreq;
                if (req[idx]) begin
                    res = {1'b1, idx[2:0]};
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/comparator_4_bit.sv
// Combinational unsigned 4-bit magnitude comparator.
module comparator_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       a_eq_b,
    output logic       a_gt_b,
    output logic       a_lt_b
);

    assign a_eq_b = (a == b);
    assign a_gt_b = (a > b);
    assign a_lt_b = (a < b);

endmodule

// File: rtl/cmp4_share_arb.sv
// Arbiter sharing one comparator_4_bit among NREQ requesters.
// Define CMP_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module cmp4_share_arb
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = CMP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       a_bus,
    input  logic [NREQ*W-1:0]       b_bus,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    a_eq_b,
    output logic                    a_gt_b,
    output logic                    a_lt_b
);

    localparam int IDW = $clog2(NREQ);

    state_e       state_r;
    logic [W-1:0] a_q_r;
    logic [W-1:0] b_q_r;
    logic [2:0]   ptr_s;
    logic [3:0]   pick_s;
    logic [2:0]   pick_idx_s;
    logic [W-1:0] a_sel_s;
    logic [W-1:0] b_sel_s;
    logic         eq_s;
    logic         gt_s;
    logic         lt_s;

`ifdef CMP_ARB_RR_EN
    logic [IDW-1:0] ptr_r;

    // Round-robin pointer: moves past the requester just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {IDW{1'b0}};
        end else if (state_r == ST_RESPOND) begin
            ptr_r <= (gnt_id == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_id + IDW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = 3'(ptr_r);
`else
    assign ptr_s = 3'b000;
`endif

    assign pick_s     = rr_pick(MAX_REQ'(req), ptr_s, NREQ);
    assign pick_idx_s = pick_s[2:0];

    // Operand slice of the candidate winner.
    always_comb begin
        a_sel_s = {W{1'b0}};
        b_sel_s = {W{1'b0}};
        if (pick_s[3]) begin
            a_sel_s = a_bus[int'(pick_idx_s)*W +: W];
            b_sel_s = b_bus[int'(pick_idx_s)*W +: W];
        end else begin
            a_sel_s = {W{1'b0}};
            b_sel_s = {W{1'b0}};
        end
    end

    comparator_4_bit u_cmp (
        .a      (a_q_r),
        .b      (b_q_r),
        .a_eq_b (eq_s),
        .a_gt_b (gt_s),
        .a_lt_b (lt_s)
    );

    // Sequencer: IDLE -> COMPARE -> RESPOND -> IDLE, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_q_r   <= {W{1'b0}};
            b_q_r   <= {W{1'b0}};
            gnt     <= {NREQ{1'b0}};
            ack     <= {NREQ{1'b0}};
            gnt_id  <= {IDW{1'b0}};
            a_eq_b  <= 1'b0;
            a_gt_b  <= 1'b0;
            a_lt_b  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack <= {NREQ{1'b0}};
                    if (pick_s[3]) begin
                        a_q_r   <= a_sel_s;
                        b_q_r   <= b_sel_s;
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        gnt_id  <= IDW'(pick_idx_s);
                        state_r <= ST_COMPARE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMPARE: begin
                    a_eq_b  <= eq_s;
                    a_gt_b  <= gt_s;
                    a_lt_b  <= lt_s;
                    ack     <= gnt;
                    state_r <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    ack     <= {NREQ{1'b0}};
                    gnt     <= {NREQ{1'b0}};
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack     <= {NREQ{1'b0}};
                    gnt     <= {NREQ{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp4_share_arb.sv
// Directed bench for cmp4_share_arb: vector table plus multi-cycle corner sequences.
module tb_cmp4_share_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        a_eq_b;
    logic        a_gt_b;
    logic        a_lt_b;

    int passed;
    int total;

    cmp4_share_arb dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .gnt    (gnt),
        .ack    (ack),
        .gnt_id (gnt_id),
        .a_eq_b (a_eq_b),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] flags;   // {eq, gt, lt}
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] onehot;
        onehot = 4'b0001 << v.id;
        a_bus[v.id*4 +: 4] = v.a;
        b_bus[v.id*4 +: 4] = v.b;
        req = onehot;
        tick();
        chk("vec_gnt", 32'(gnt), 32'(onehot));
        chk("vec_gnt_id", 32'(gnt_id), 32'(v.id));
        chk("vec_no_ack_yet", 32'(ack), 32'd0);
        tick();
        req = 4'b0000;
        chk("vec_ack", 32'(ack), 32'(onehot));
        chk("vec_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(v.flags));
        tick();
        chk("vec_ack_drop", 32'(ack), 32'd0);
    endtask

    initial begin
        int exp_order[5];
        bit found;
        passed = 0;
        total  = 0;

        vecs[0] = '{2, 4'b1010, 4'b1011, 3'b001};
        vecs[1] = '{0, 4'b1111, 4'b1111, 3'b100};
        vecs[2] = '{1, 4'b1010, 4'b0000, 3'b010};
        vecs[3] = '{0, 4'b1000, 4'b0111, 3'b010};
        vecs[4] = '{3, 4'b0000, 4'b0001, 3'b001};
        vecs[5] = '{3, 4'b0000, 4'b0000, 3'b100};

`ifdef CMP_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 0, 1, 0};
`endif

        // Reset with all requests pending.
        rst   = 1'b1;
        req   = 4'b1111;
        a_bus = 16'h0000;
        b_bus = 16'h0000;
        tick();
        tick();
        chk("rst_outputs", 32'({gnt, ack, gnt_id, a_eq_b, a_gt_b, a_lt_b}), 32'd0);
        rst = 1'b0;
        chk("rst_no_gnt_at_release", 32'(gnt), 32'd0);
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("post_rst_ack", 32'(ack), 32'h1);
        chk("post_rst_eq", 32'(a_eq_b), 32'd1);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Fairness: all requesting, each drops for one cycle after its ack.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                tick();
                if (ack != 4'b0000) found = 1'b1;
            end
            chk("fair_ack_seen", 32'(found), 32'd1);
            chk("fair_gnt_id", 32'(gnt_id), 32'(exp_order[k]));
            chk("fair_ack", 32'(ack), 32'(4'b0001 << exp_order[k]));
            req = (k == 4) ? 4'b0000 : (req & ~ack);
            tick();
            tick();
            if (k != 4) req = 4'b1111;
        end

        // Reset during COMPARE discards the transaction and clears the pointer.
        a_bus[8 +: 4] = 4'b0011;
        b_bus[8 +: 4] = 4'b0001;
        req = 4'b0100;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        tick();
        chk("mid_rst_no_ack", 32'(ack), 32'd0);
        chk("mid_rst_gnt_clear", 32'(gnt), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("mid_rst_ptr_zero", 32'(gnt_id), 32'd0);
        req = 4'b0000;
        tick();
        chk("mid_rst_next_ack", 32'(ack), 32'h1);
        tick();

        // Operand change after latching is ignored.
        a_bus[4 +: 4] = 4'b0000;
        b_bus[4 +: 4] = 4'b1111;
        req = 4'b0010;
        tick();
        a_bus[4 +: 4] = 4'b1111;
        req = 4'b0000;
        tick();
        chk("latch_ack", 32'(ack), 32'h2);
        chk("latch_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'b001);
        tick();
        chk("final_idle_ack", 32'(ack), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
